// File: rtl/mem_if_pkg.sv
// Shared types for the memory access master.
// States, operation codes, address limits and bus strobe encodings.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WAIT,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH,
    OP_LOAD,
    OP_STORE
  } op_t;

  localparam int unsigned INSTR_TOP = 1023;
  localparam int unsigned MEM_TOP   = 4095;

  typedef struct packed {
    logic rd;
    logic wr;
  } bus_enc_t;

  localparam bus_enc_t BUS_FETCH = '{rd: 1'b0, wr: 1'b0};
  localparam bus_enc_t BUS_LOAD  = '{rd: 1'b1, wr: 1'b0};
  localparam bus_enc_t BUS_STORE = '{rd: 1'b0, wr: 1'b1};

  function automatic bus_enc_t op_bus(op_t op);
    bus_enc_t e;
    unique case (op)
      OP_LOAD:  e = BUS_LOAD;
      OP_STORE: e = BUS_STORE;
      default:  e = BUS_FETCH;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/mem_access_master_if.sv
// Request handshake and memory bus bundle.
// master: the access engine; slave: requester plus memory.
interface mem_access_master_if;
  logic        fetch_req;
  logic        ld_req;
  logic        st_req;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        busy;
  logic        done;
  logic        fault;
  logic [15:0] rdata;
  logic [15:0] Mem_Address;
  logic        Mem_Read;
  logic        Mem_Write;
  logic [15:0] Write_Data;
  logic [15:0] Result;

  modport master (
    input  fetch_req, ld_req, st_req,
    input  req_addr, req_wdata, Result,
    output busy, done, fault, rdata,
    output Mem_Address, Mem_Read,
    output Mem_Write, Write_Data
  );

  modport slave (
    output fetch_req, ld_req, st_req,
    output req_addr, req_wdata, Result,
    input  busy, done, fault, rdata,
    input  Mem_Address, Mem_Read,
    input  Mem_Write, Write_Data
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter for bus hold time.
// Saturates at zero and flags it.
module mem_wait_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rest)
      cnt_q <= '0;
    else if (load)
      cnt_q <= load_val;
    else if (dec && cnt_q != '0)
      cnt_q <= cnt_q - 1'b1;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_master.sv
// CPU-side initiator for the 16-bit big-endian memory.
// Define ALIGN_CHECK_EN to fault odd addresses.
module mem_access_master #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned INSTR_TOP   = mem_if_pkg::INSTR_TOP,
  parameter int unsigned MEM_TOP     = mem_if_pkg::MEM_TOP
) (
  input logic                 clk,
  input logic                 rest,
  mem_access_master_if.master bus
);
  import mem_if_pkg::*;

  localparam logic [16:0] ITOP = 17'(INSTR_TOP);
  localparam logic [16:0] MTOP = 17'(MEM_TOP);
  localparam logic [3:0]  WLD  = 4'(WAIT_CYCLES);

  state_t      state_q, state_d;
  op_t         op_q, req_op;
  bus_enc_t    enc;
  logic        req_any, accept, flt, flt_q;
  logic        zero, busy_w, last;
  logic        rd_q, wr_q;
  logic [16:0] addr_x, addr_p1;
  logic [15:0] addr_q, wdata_q, rdata_q;

  assign req_any = bus.st_req | bus.ld_req
                 | bus.fetch_req;
  assign addr_x  = {1'b0, bus.req_addr};
  // 17 bits so 16'hFFFF+1 cannot wrap past the check
  assign addr_p1 = addr_x + 17'd1;
  assign busy_w  = (state_q == ACCESS)
                 | (state_q == WAIT);
  assign last    = busy_w & zero;
  assign enc     = op_bus(req_op);

  always_comb begin
    req_op = OP_FETCH;
    priority case (1'b1)
      bus.st_req: req_op = OP_STORE;
      bus.ld_req: req_op = OP_LOAD;
      default:    req_op = OP_FETCH;
    endcase
  end

  always_comb begin
    flt = (addr_p1 > MTOP);
    unique case (req_op)
      OP_FETCH: if (addr_x > ITOP)  flt = 1'b1;
      OP_STORE: if (addr_x <= ITOP) flt = 1'b1;
      default:  ;
    endcase
`ifdef ALIGN_CHECK_EN
    if (bus.req_addr[0]) flt = 1'b1;
`endif
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_any) begin
          accept  = 1'b1;
          state_d = flt ? DONE : ACCESS;
        end
      end
      ACCESS,
      WAIT:    state_d = zero ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  mem_wait_timer #(.WIDTH(4)) u_timer (
    .clk      (clk),
    .rest     (rest),
    .load     (accept),
    .dec      (busy_w),
    .load_val (WLD),
    .zero     (zero)
  );

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      op_q    <= OP_FETCH;
      flt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q  <= req_op;
        flt_q <= flt;
        if (!flt) begin
          addr_q <= bus.req_addr;
          rd_q   <= enc.rd;
          wr_q   <= enc.wr;
          if (req_op == OP_STORE)
            wdata_q <= bus.req_wdata;
        end
      end
      if (last) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        if (op_q != OP_STORE)
          rdata_q <= bus.Result;
      end
    end
  end

  assign bus.busy        = busy_w;
  assign bus.done        = (state_q == DONE);
  assign bus.fault       = (state_q == DONE) & flt_q;
  assign bus.rdata       = rdata_q;
  assign bus.Mem_Address = addr_q;
  assign bus.Mem_Read    = rd_q;
  assign bus.Mem_Write   = wr_q;
  assign bus.Write_Data  = wdata_q;

endmodule
